// File: rtl/fifo_flops_push_credit_sync.sv
// Flop-based FIFO with a credit-returning push side and a show-ahead valid/ready pop side.
// The sender's credit counter is modelled locally so upstream logic can gate pushes on it.
module fifo_flops_push_credit_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             push_clk,
    input  logic             push_rst,
    input  logic             push_sender_in_reset,
    output logic             push_receiver_in_reset,
    input  logic             push_credit_stall,
    output logic             push_credit,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_full,
    output logic [CNT_W-1:0] push_slots,
    input  logic [CNT_W-1:0] credit_initial_push,
    input  logic [CNT_W-1:0] credit_withhold_push,
    output logic [CNT_W-1:0] credit_count_push,
    output logic [CNT_W-1:0] credit_available_push,
    input  logic             pop_ready,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_empty,
    output logic [CNT_W-1:0] pop_items
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] occupancy;

    logic             push_accept;
    logic             pop_fire;
    logic             credit_ok;
    logic [CNT_W+1:0] credit_sum;

    assign push_full  = (occupancy == DEPTH_CNT);
    assign push_slots = DEPTH_CNT - occupancy;
    assign pop_empty  = (occupancy == '0);
    assign pop_items  = occupancy;
    assign pop_valid  = !pop_empty;
    assign pop_data   = mem[rd_ptr];

    // Pushes without a credit or into a full FIFO are sender errors and are silently dropped.
    assign push_accept = push_valid && (credit_count_push != '0) &&
                         (occupancy < DEPTH_CNT) && !push_rst;
    assign pop_fire    = pop_valid && pop_ready;

    // Credits in flight (held by sender, sitting in the FIFO, or on the wire) must stay below the budget.
    assign credit_sum = {2'b00, credit_count_push} + {2'b00, occupancy} +
                        (CNT_W + 2)'(push_credit);
    assign credit_ok  = !push_receiver_in_reset && !push_sender_in_reset &&
                        !push_credit_stall &&
                        (credit_sum < {2'b00, credit_initial_push});

    assign credit_available_push = (credit_count_push > credit_withhold_push) ?
                                   (credit_count_push - credit_withhold_push) : '0;

    always_ff @(posedge push_clk) begin
        if (push_accept) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge push_clk) begin
        if (push_rst) begin
            push_receiver_in_reset <= 1'b1;
            push_credit            <= 1'b0;
            credit_count_push      <= '0;
            wr_ptr                 <= '0;
            rd_ptr                 <= '0;
            occupancy              <= '0;
        end else begin
            push_receiver_in_reset <= 1'b0;
            push_credit            <= credit_ok;

            case ({push_credit, push_accept})
                2'b10:   credit_count_push <= credit_count_push + 1'b1;
                2'b01:   credit_count_push <= credit_count_push - 1'b1;
                default: credit_count_push <= credit_count_push;
            endcase

            if (push_accept) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end

            case ({push_accept, pop_fire})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_flops_push_credit_sync.sv
// Directed bench for fifo_flops_push_credit_sync: credit ramp, push/pop ordering, stall, reset and full/wrap cases.
module tb_fifo_flops_push_credit_sync;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    logic             push_clk = 1'b0;
    logic             push_rst;
    logic             push_sender_in_reset;
    logic             push_receiver_in_reset;
    logic             push_credit_stall;
    logic             push_credit;
    logic             push_valid;
    logic [WIDTH-1:0] push_data;
    logic             push_full;
    logic [CNT_W-1:0] push_slots;
    logic [CNT_W-1:0] credit_initial_push;
    logic [CNT_W-1:0] credit_withhold_push;
    logic [CNT_W-1:0] credit_count_push;
    logic [CNT_W-1:0] credit_available_push;
    logic             pop_ready;
    logic             pop_valid;
    logic [WIDTH-1:0] pop_data;
    logic             pop_empty;
    logic [CNT_W-1:0] pop_items;

    int check_count = 0;
    int pass_count  = 0;

    fifo_flops_push_credit_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .push_clk               (push_clk),
        .push_rst               (push_rst),
        .push_sender_in_reset   (push_sender_in_reset),
        .push_receiver_in_reset (push_receiver_in_reset),
        .push_credit_stall      (push_credit_stall),
        .push_credit            (push_credit),
        .push_valid             (push_valid),
        .push_data              (push_data),
        .push_full              (push_full),
        .push_slots             (push_slots),
        .credit_initial_push    (credit_initial_push),
        .credit_withhold_push   (credit_withhold_push),
        .credit_count_push      (credit_count_push),
        .credit_available_push  (credit_available_push),
        .pop_ready              (pop_ready),
        .pop_valid              (pop_valid),
        .pop_data               (pop_data),
        .pop_empty              (pop_empty),
        .pop_items              (pop_items)
    );

    always #5 push_clk = ~push_clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge push_clk);
        #1;
    endtask

    task automatic test_reset();
        int pulses;
        int rises;
        int first_idx;
        int max_count;
        logic prev;
        push_rst = 1'b1;
        tick(); tick(); tick();
        check_count++; if (push_receiver_in_reset !== 1'b1) $display("[TB] FAIL rst_recv: got %0b expected 1", push_receiver_in_reset); else pass_count++;
        check_count++; if (pop_empty !== 1'b1 || pop_valid !== 1'b0) $display("[TB] FAIL rst_empty: got empty=%0b valid=%0b expected 1/0", pop_empty, pop_valid); else pass_count++;
        check_count++; if (pop_items !== 5'd0 || push_slots !== 5'd16 || push_full !== 1'b0) $display("[TB] FAIL rst_occ: got items=%0d slots=%0d full=%0b expected 0/16/0", pop_items, push_slots, push_full); else pass_count++;
        check_count++; if (credit_count_push !== 5'd0 || push_credit !== 1'b0) $display("[TB] FAIL rst_credit: got count=%0d credit=%0b expected 0/0", credit_count_push, push_credit); else pass_count++;
        push_rst = 1'b0;
        check_count++; if (push_receiver_in_reset !== 1'b1) $display("[TB] FAIL rel_recv_hold: got %0b expected 1", push_receiver_in_reset); else pass_count++;
        tick();
        check_count++; if (push_receiver_in_reset !== 1'b0 || push_credit !== 1'b0) $display("[TB] FAIL rel_recv_drop: got recv=%0b credit=%0b expected 0/0", push_receiver_in_reset, push_credit); else pass_count++;
        pulses = 0; rises = 0; first_idx = -1; max_count = 0; prev = 1'b0;
        for (int i = 0; i < 22; i++) begin
            tick();
            if (push_credit === 1'b1) begin
                pulses++;
                if (first_idx < 0) first_idx = i;
                if (!prev) rises++;
            end
            prev = push_credit;
            if (int'(credit_count_push) > max_count) max_count = int'(credit_count_push);
        end
        check_count++; if (first_idx !== 0) $display("[TB] FAIL ramp_start: got first pulse at %0d expected 0", first_idx); else pass_count++;
        check_count++; if (pulses !== 16 || rises !== 1) $display("[TB] FAIL ramp_pulses: got %0d pulses in %0d bursts expected 16 in 1", pulses, rises); else pass_count++;
        check_count++; if (credit_count_push !== 5'd16 || max_count !== 16) $display("[TB] FAIL ramp_count: got %0d (max %0d) expected 16", credit_count_push, max_count); else pass_count++;
        check_count++; if (credit_available_push !== 5'd12) $display("[TB] FAIL ramp_avail: got %0d expected 12", credit_available_push); else pass_count++;
    endtask

    task automatic test_push();
        for (int i = 0; i < 10; i++) begin
            push_valid = 1'b1;
            push_data  = 8'(i);
            tick();
            if (i == 0) begin
                check_count++; if (pop_valid !== 1'b1 || pop_data !== 8'd0) $display("[TB] FAIL push_latency: got valid=%0b data=%0d expected 1/0", pop_valid, pop_data); else pass_count++;
            end
        end
        push_valid = 1'b0;
        check_count++; if (pop_items !== 5'd10 || push_slots !== 5'd6 || pop_empty !== 1'b0) $display("[TB] FAIL push_occ: got items=%0d slots=%0d empty=%0b expected 10/6/0", pop_items, push_slots, pop_empty); else pass_count++;
        check_count++; if (credit_count_push !== 5'd6 || credit_available_push !== 5'd2) $display("[TB] FAIL push_credit: got count=%0d avail=%0d expected 6/2", credit_count_push, credit_available_push); else pass_count++;
        tick(); tick();
        check_count++; if (push_credit !== 1'b0 || credit_count_push !== 5'd6) $display("[TB] FAIL push_no_return: got credit=%0b count=%0d expected 0/6", push_credit, credit_count_push); else pass_count++;
    endtask

    task automatic test_pop();
        int pulses;
        pulses = 0;
        pop_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_count++; if (pop_data !== 8'(i)) $display("[TB] FAIL pop_order[%0d]: got %0d expected %0d", i, pop_data, i); else pass_count++;
            if (push_credit === 1'b1) pulses++;
            tick();
        end
        pop_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            if (push_credit === 1'b1) pulses++;
            tick();
        end
        check_count++; if (pop_empty !== 1'b1 || pop_valid !== 1'b0) $display("[TB] FAIL pop_empty: got empty=%0b valid=%0b expected 1/0", pop_empty, pop_valid); else pass_count++;
        check_count++; if (pulses !== 10) $display("[TB] FAIL pop_returns: got %0d pulses expected 10", pulses); else pass_count++;
        check_count++; if (credit_count_push !== 5'd16) $display("[TB] FAIL pop_count: got %0d expected 16", credit_count_push); else pass_count++;
    endtask

    task automatic test_stall();
        int pulses;
        push_rst = 1'b1;
        tick(); tick();
        push_rst = 1'b0;
        push_credit_stall = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (push_credit === 1'b1) pulses++;
        end
        check_count++; if (pulses !== 0 || credit_count_push !== 5'd0) $display("[TB] FAIL stall_hold: got %0d pulses count=%0d expected 0/0", pulses, credit_count_push); else pass_count++;
        push_credit_stall = 1'b0;
        push_sender_in_reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (push_credit === 1'b1) pulses++;
        end
        check_count++; if (pulses !== 0 || credit_count_push !== 5'd0) $display("[TB] FAIL sender_rst_hold: got %0d pulses count=%0d expected 0/0", pulses, credit_count_push); else pass_count++;
        push_sender_in_reset = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (push_credit === 1'b1) pulses++;
        end
        check_count++; if (pulses !== 16 || credit_count_push !== 5'd16) $display("[TB] FAIL stall_resume: got %0d pulses count=%0d expected 16/16", pulses, credit_count_push); else pass_count++;
    endtask

    task automatic test_reset_mid();
        int pulses;
        for (int i = 0; i < 3; i++) begin
            push_valid = 1'b1;
            push_data  = 8'h30 + 8'(i);
            tick();
        end
        push_valid = 1'b0;
        check_count++; if (pop_items !== 5'd3 || credit_count_push !== 5'd13) $display("[TB] FAIL mid_pre: got items=%0d count=%0d expected 3/13", pop_items, credit_count_push); else pass_count++;
        push_rst = 1'b1;
        tick(); tick();
        check_count++; if (push_receiver_in_reset !== 1'b1 || pop_items !== 5'd0 || credit_count_push !== 5'd0) $display("[TB] FAIL mid_rst: got recv=%0b items=%0d count=%0d expected 1/0/0", push_receiver_in_reset, pop_items, credit_count_push); else pass_count++;
        push_rst   = 1'b0;
        push_valid = 1'b1;
        push_data  = 8'h55;
        tick();
        push_valid = 1'b0;
        check_count++; if (pop_items !== 5'd0 || push_receiver_in_reset !== 1'b0) $display("[TB] FAIL zero_credit_drop: got items=%0d recv=%0b expected 0/0", pop_items, push_receiver_in_reset); else pass_count++;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (push_credit === 1'b1) pulses++;
        end
        check_count++; if (pulses !== 16 || credit_count_push !== 5'd16) $display("[TB] FAIL mid_ramp: got %0d pulses count=%0d expected 16/16", pulses, credit_count_push); else pass_count++;
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < 5; i++) begin
            push_valid = 1'b1;
            push_data  = 8'hA0 + 8'(i);
            tick();
        end
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_count++; if (pop_data !== 8'hA0 + 8'(i)) $display("[TB] FAIL offset_pop[%0d]: got %0h expected %0h", i, pop_data, 8'hA0 + 8'(i)); else pass_count++;
            tick();
        end
        pop_ready = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check_count++; if (credit_count_push !== 5'd16 || pop_empty !== 1'b1) $display("[TB] FAIL offset_refill: got count=%0d empty=%0b expected 16/1", credit_count_push, pop_empty); else pass_count++;
        for (int i = 0; i < 16; i++) begin
            push_valid = 1'b1;
            push_data  = 8'h10 + 8'(i);
            tick();
        end
        check_count++; if (push_full !== 1'b1 || push_slots !== 5'd0 || pop_items !== 5'd16 || credit_count_push !== 5'd0) $display("[TB] FAIL full_state: got full=%0b slots=%0d items=%0d count=%0d expected 1/0/16/0", push_full, push_slots, pop_items, credit_count_push); else pass_count++;
        push_data = 8'hEE;
        tick();
        check_count++; if (pop_items !== 5'd16 || pop_data !== 8'h10 || credit_count_push !== 5'd0) $display("[TB] FAIL full_drop: got items=%0d head=%0h count=%0d expected 16/10/0", pop_items, pop_data, credit_count_push); else pass_count++;
        pop_ready = 1'b1;
        check_count++; if (pop_data !== 8'h10) $display("[TB] FAIL full_pop[0]: got %0h expected 10", pop_data); else pass_count++;
        tick();
        push_valid = 1'b0;
        check_count++; if (pop_items !== 5'd15) $display("[TB] FAIL full_push_pop: got items=%0d expected 15", pop_items); else pass_count++;
        for (int i = 1; i < 16; i++) begin
            check_count++; if (pop_data !== 8'h10 + 8'(i)) $display("[TB] FAIL full_pop[%0d]: got %0h expected %0h", i, pop_data, 8'h10 + 8'(i)); else pass_count++;
            tick();
        end
        pop_ready = 1'b0;
        check_count++; if (pop_empty !== 1'b1 || pop_items !== 5'd0) $display("[TB] FAIL wrap_empty: got empty=%0b items=%0d expected 1/0", pop_empty, pop_items); else pass_count++;
    endtask

    initial begin
        push_rst             = 1'b1;
        push_sender_in_reset = 1'b0;
        push_credit_stall    = 1'b0;
        push_valid           = 1'b0;
        push_data            = '0;
        pop_ready            = 1'b0;
        credit_initial_push  = 5'd16;
        credit_withhold_push = 5'd4;
        test_reset();
        test_push();
        test_pop();
        test_stall();
        test_reset_mid();
        test_full_wrap();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/fifo_flops_push_credit_sync.md
Name: fifo_flops_push_credit_sync

Overview:
Flop-based FIFO with a credit-based push interface and a valid/ready pop interface, clocked by a single clock. The receiver returns credits to the sender through push_credit, one per cycle, up to credit_initial_push credits outstanding. The block also models the sender's credit counter, which lets upstream logic gate pushes on credit_available_push. It sits between a credit-flow producer and a ready/valid consumer.

Parameters:
WIDTH, 8, data width in bits.
DEPTH, 16, number of FIFO entries.
CNT_W, 5, counter width, equal to clog2(DEPTH+1).

Ports:
push_clk  in  1  single clock for all logic, including the pop side.
push_rst  in  1  synchronous, active-high reset for the whole block.
push_sender_in_reset  in  1  sender is in reset; credit return is suppressed.
push_receiver_in_reset  out  1  receiver is in reset; sender must not push.
push_credit_stall  in  1  holds off credit return.
push_credit  out  1  one-cycle pulse returning one credit.
push_valid  in  1  write strobe; consumes one credit.
push_data  in  WIDTH  write data.
push_full  out  1  occupancy == DEPTH.
push_slots  out  CNT_W  DEPTH - occupancy.
credit_initial_push  in  CNT_W  total credits to circulate; must be <= DEPTH.
credit_withhold_push  in  CNT_W  credits the sender must hold in reserve.
credit_count_push  out  CNT_W  credits currently held by the sender.
credit_available_push  out  CNT_W  usable credits.
pop_ready  in  1  consumer accepts the head entry.
pop_valid  out  1  FIFO is non-empty.
pop_data  out  WIDTH  head entry (show-ahead).
pop_empty  out  1  occupancy == 0.
pop_items  out  CNT_W  occupancy.

Behaviour:
- Clocking and reset: one clock, push_clk; reset is synchronous and active-high on push_rst.
- While push_rst = 1, all of the following are cleared:
  - wr_ptr = 0, rd_ptr = 0, occupancy = 0.
  - credit_count_push = 0, push_credit = 0.
  - pop_valid = 0, pop_empty = 1, push_full = 0, push_slots = DEPTH, pop_items = 0.
  - Storage contents are not reset.
- push_receiver_in_reset is a register: 1 while push_rst = 1 and for the first cycle after push_rst deasserts, otherwise 0.
- Credit return (push_credit is a registered output):
  - push_credit is set next cycle when all of these hold: push_receiver_in_reset = 0, push_sender_in_reset = 0, push_credit_stall = 0, and (credit_count_push + occupancy + push_credit) < credit_initial_push.
  - Rate is at most one credit per cycle.
  - With occupancy 0 after reset, exactly credit_initial_push pulses occur on consecutive cycles.
- credit_count_push update each cycle:
  - +1 when push_credit = 1.
  - -1 when an accepted push occurs.
  - Unchanged when both happen in the same cycle.
  - Never exceeds credit_initial_push.
- credit_available_push = credit_count_push - credit_withhold_push when credit_count_push > credit_withhold_push, else 0. It is combinational from the registered count.
- Push accept:
  - A push is accepted when push_valid = 1, credit_count_push > 0, occupancy < DEPTH, and push_rst = 0.
  - An accepted push writes push_data at wr_ptr; wr_ptr wraps modulo DEPTH.
  - push_valid with zero credits or a full FIFO is an error: the push is dropped and no state changes.
- Pop:
  - pop_valid = !pop_empty; pop_data = mem[rd_ptr].
  - A pop happens when pop_valid && pop_ready; rd_ptr wraps modulo DEPTH.
  - A popped entry frees a slot, which re-enables credit return on a later cycle.
- Latency:
  - Data pushed in cycle N is visible on pop_valid/pop_data in cycle N+1.
  - A popped slot can produce push_credit at the earliest in cycle N+1 after the pop.
- Simultaneous push and pop: occupancy is unchanged. This is legal when full only if the FIFO is not full before the edge, i.e. a push into a full FIFO is dropped even with a concurrent pop.
- Reset mid-operation: all contents are discarded and credits restart from 0. push_sender_in_reset = 1 clears nothing; it only blocks credit return.
- Outputs push_full, push_slots, pop_empty and pop_items derive from the registered occupancy.

Test Plan:
- Reset with credit_initial_push = 16, credit_withhold_push = 4 -> after release, 16 consecutive push_credit pulses; credit_count_push ramps 0..16; credit_available_push = 12 at the end.
- Push 10 words with values 0..9 using credits, pop_ready = 0 -> pop_items = 10, push_slots = 6, credit_count_push = 6, credit_available_push = 2, pop_empty = 0.
- pop_ready = 1 for 10 cycles -> pop_data reads 0..9 in order; pop_empty = 1; 10 more push_credit pulses; credit_count_push returns to 16.
- push_credit_stall = 1 during the post-reset ramp -> no push_credit while stalled; the ramp resumes afterwards; total credits still equal 16.
- Assert push_rst mid-traffic, then release -> push_receiver_in_reset = 1 through the reset plus one cycle; occupancy = 0; credit_count_push = 0; the credit ramp restarts.
- Push 16 entries, then push_valid with credits forced to 0 or while full -> push is dropped; push_full = 1; pop order is intact, including wrap-around of both pointers.
